// File: rtl/jtag_tdo_capture_if.sv
// jtag_tdo_capture_if: capture control, status and vector_2 RAM write port bundle
interface jtag_tdo_capture_if #(
   parameter int D_WIDTH = 8,
   parameter int A_WIDTH = 12
);
   logic               capture_start;
   logic               capture_stop;
   logic               tdo;
   logic               tdo_valid;
   logic [A_WIDTH-1:0] base_addr;
   logic [A_WIDTH-1:0] end_addr;
   logic [A_WIDTH-1:0] vector_2_addr;
   logic               vector_2_we;
   logic [D_WIDTH-1:0] vector_2_wr_data;
   logic               busy;
   logic               done;
   logic               overflow;
   logic [31:0]        bit_count;

   modport master (
      output capture_start, capture_stop, tdo, tdo_valid, base_addr, end_addr,
      input  vector_2_addr, vector_2_we, vector_2_wr_data, busy, done, overflow, bit_count
   );

   modport slave (
      input  capture_start, capture_stop, tdo, tdo_valid, base_addr, end_addr,
      output vector_2_addr, vector_2_we, vector_2_wr_data, busy, done, overflow, bit_count
   );
endinterface

// File: rtl/jtag_tdo_capture.sv
// jtag_tdo_capture: packs the TDO bit stream LSB-first into words written to vector_2
module jtag_tdo_capture #(
   parameter int D_WIDTH = 8,
   parameter int A_WIDTH = 12
) (
   input logic              clk,
   input logic              reset,
   jtag_tdo_capture_if.slave bus
);
   localparam int IW = $clog2(D_WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH, DONE} state_t;

   state_t             state_q, state_d;
   logic [A_WIDTH:0]   ptr_q, ptr_d;
   logic [A_WIDTH-1:0] end_q, end_d, addr_q, addr_d;
   logic [D_WIDTH-1:0] shift_q, shift_d, data_q, data_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic [31:0]        cnt_q, cnt_d;
   logic               we_q, we_d, busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
   logic               room;
   logic [D_WIDTH-1:0] shift_nx;

   // the pointer carries an extra bit so stepping past all-ones reads as "no room"
   assign room     = ptr_q <= {1'b0, end_q};
   assign shift_nx = shift_q | ({{(D_WIDTH-1){1'b0}}, bus.tdo} << idx_q);

   // next-state, packing and write-port logic
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      end_d   = end_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      data_d  = data_q;
      we_d    = 1'b0;
      done_d  = done_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE, DONE: if (bus.capture_start) begin
            state_d = CAPTURE;
            ptr_d   = {1'b0, bus.base_addr};
            end_d   = bus.end_addr;
            shift_d = '0;
            idx_d   = '0;
            cnt_d   = '0;
            done_d  = 1'b0;
            ovf_d   = 1'b0;
         end
         CAPTURE: begin
            if (bus.tdo_valid) begin
               if (!room) ovf_d = 1'b1;
               else begin
                  cnt_d = cnt_q + 32'd1;
                  if (idx_q == IW'(D_WIDTH - 1)) begin
                     we_d    = 1'b1;
                     addr_d  = ptr_q[A_WIDTH-1:0];
                     data_d  = shift_nx;
                     ptr_d   = ptr_q + (A_WIDTH+1)'(1);
                     idx_d   = '0;
                     shift_d = '0;
                  end else begin
                     shift_d = shift_nx;
                     idx_d   = idx_q + IW'(1);
                  end
               end
            end
            if (bus.capture_stop) state_d = FLUSH;
         end
         FLUSH: begin
            if (idx_q != '0 && room) begin
               we_d   = 1'b1;
               addr_d = ptr_q[A_WIDTH-1:0];
               data_d = shift_q;
            end
            state_d = DONE;
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
      busy_d = state_d == CAPTURE || state_d == FLUSH;
   end

   // state and output registers, cleared asynchronously
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         end_q   <= '0;
         shift_q <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         end_q   <= end_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         we_q    <= we_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.vector_2_addr    = addr_q;
   assign bus.vector_2_we      = we_q;
   assign bus.vector_2_wr_data = data_q;
   assign bus.busy             = busy_q;
   assign bus.done             = done_q;
   assign bus.overflow         = ovf_q;
   assign bus.bit_count        = cnt_q;
endmodule

// File: tb/tb_jtag_tdo_capture.sv
// tb_jtag_tdo_capture: randomized runs against a word-level capture model with a write scoreboard
module tb_jtag_tdo_capture;
   localparam int DW = 8;
   localparam int AW = 12;

   typedef struct {
      int c;
      int a;
      int d;
   } wr_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   wr_t  exp_q[$];

   jtag_tdo_capture_if #(.D_WIDTH(DW), .A_WIDTH(AW)) bus ();
   jtag_tdo_capture #(.D_WIDTH(DW), .A_WIDTH(AW)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
      end
   endtask

   // scoreboard: every observed write must match the oldest expected write, including its cycle
   always @(negedge clk) begin
      wr_t e;
      if (!reset && bus.vector_2_we === 1'b1) begin
         if (exp_q.size() == 0) chk("unexpected_write", {32'd0, 20'd0, bus.vector_2_addr}, 64'hFFFF_FFFF);
         else begin
            e = exp_q.pop_front();
            chk("wr_cycle", 64'(cyc), 64'(e.c));
            chk("wr_addr", 64'(bus.vector_2_addr), 64'(e.a));
            chk("wr_data", 64'(bus.vector_2_wr_data), 64'(e.d));
         end
      end
   end

   // one capture run; the model derives capacity and word contents from the address window
   task automatic run(input int base, input int endv, input logic [63:0] pat, input int nbits,
                      input int gapmax, input bit coinc_in, input int poke);
      int  cap, n, cstop, rem;
      bit  coinc, last;
      coinc = coinc_in && nbits > 0;
      cap   = (endv >= base) ? (endv - base + 1) * DW : 0;
      n     = (nbits < cap) ? nbits : cap;
      cstop = 0;
      @(negedge clk);
      bus.base_addr     = AW'(base);
      bus.end_addr      = AW'(endv);
      bus.capture_start = 1'b1;
      @(negedge clk);
      bus.capture_start = 1'b0;
      chk("start_busy", 64'(bus.busy), 64'd1);
      chk("start_done", 64'(bus.done), 64'd0);
      chk("start_ovf", 64'(bus.overflow), 64'd0);
      chk("start_count", 64'(bus.bit_count), 64'd0);
      for (int i = 0; i < nbits; i++) begin
         repeat ($urandom_range(gapmax, 0)) @(negedge clk);
         bus.tdo       = pat[i];
         bus.tdo_valid = 1'b1;
         if (i == poke) begin
            bus.capture_start = 1'b1;
            bus.base_addr     = 12'h100;
         end
         last = coinc && i == nbits - 1;
         if (last) begin
            bus.capture_stop = 1'b1;
            cstop = cyc;
         end
         if (i < cap && i % DW == DW - 1)
            exp_q.push_back('{cyc + 1, base + i / DW, int'((pat >> (i - DW + 1)) & 64'hFF)});
         @(negedge clk);
         bus.tdo_valid     = 1'b0;
         bus.capture_start = 1'b0;
         bus.capture_stop  = 1'b0;
         chk("bit_count", 64'(bus.bit_count), 64'((i < cap) ? i + 1 : cap));
         chk("overflow_run", 64'(bus.overflow), 64'(i >= cap));
         chk("busy_run", 64'(bus.busy), 64'd1);
      end
      if (!coinc) begin
         repeat ($urandom_range(gapmax, 0)) @(negedge clk);
         bus.capture_stop = 1'b1;
         cstop = cyc;
         @(negedge clk);
         bus.capture_stop = 1'b0;
         chk("flush_busy", 64'(bus.busy), 64'd1);
      end
      rem = n % DW;
      if (rem != 0)
         exp_q.push_back('{cstop + 2, base + n / DW, int'((pat >> (n - rem)) & ((64'd1 << rem) - 1))});
      @(negedge clk);
      chk("end_busy", 64'(bus.busy), 64'd0);
      chk("end_done", 64'(bus.done), 64'd1);
      chk("flush_we", 64'(bus.vector_2_we), 64'(rem != 0));
      chk("end_count", 64'(bus.bit_count), 64'(n));
      chk("end_ovf", 64'(bus.overflow), 64'(nbits > cap));
      repeat (3) @(negedge clk);
      chk("exp_left", 64'(exp_q.size()), 64'd0);
      chk("done_hold", 64'(bus.done), 64'd1);
      exp_q.delete();
   endtask

   initial begin
      int b, e, nb;
      bus.capture_start = 1'b0;
      bus.capture_stop  = 1'b0;
      bus.tdo           = 1'b0;
      bus.tdo_valid     = 1'b0;
      bus.base_addr     = '0;
      bus.end_addr      = '0;
      repeat (2) @(negedge clk);
      chk("rst_addr", 64'(bus.vector_2_addr), 64'd0);
      chk("rst_we", 64'(bus.vector_2_we), 64'd0);
      chk("rst_data", 64'(bus.vector_2_wr_data), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_ovf", 64'(bus.overflow), 64'd0);
      chk("rst_count", 64'(bus.bit_count), 64'd0);
      reset = 1'b0;
      // stop in IDLE is ignored
      @(negedge clk);
      bus.capture_stop = 1'b1;
      @(negedge clk);
      bus.capture_stop = 1'b0;
      @(negedge clk);
      chk("idle_stop_done", 64'(bus.done), 64'd0);
      run(12'h010, 12'hFFF, 64'hFF0D, 16, 0, 0, -1);
      run(12'h010, 12'hFFF, 64'h30D, 11, 1, 0, -1);
      run(12'h020, 12'h020, 64'hFFFFF, 20, 0, 0, -1);
      run(12'h010, 12'hFFF, 64'h5A, 8, 1, 1, -1);
      run(12'h010, 12'hFFF, 64'h3C3, 12, 1, 0, 3);
      run(12'hFFF, 12'hFFF, 64'hFFF, 12, 0, 0, -1);
      run(12'h030, 12'h02F, 64'hFF, 6, 0, 0, -1);
      // reset mid-run, then a clean run of zeros
      @(negedge clk);
      bus.base_addr = 12'h010;
      bus.end_addr  = 12'hFFF;
      bus.capture_start = 1'b1;
      @(negedge clk);
      bus.capture_start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus.tdo = 1'b1;
         bus.tdo_valid = 1'b1;
         @(negedge clk);
      end
      bus.tdo_valid = 1'b0;
      reset = 1'b1;
      #1;
      chk("mid_rst_busy", 64'(bus.busy), 64'd0);
      chk("mid_rst_count", 64'(bus.bit_count), 64'd0);
      chk("mid_rst_we", 64'(bus.vector_2_we), 64'd0);
      chk("mid_rst_done", 64'(bus.done), 64'd0);
      chk("mid_rst_ovf", 64'(bus.overflow), 64'd0);
      chk("mid_rst_addr", 64'(bus.vector_2_addr), 64'd0);
      chk("mid_rst_data", 64'(bus.vector_2_wr_data), 64'd0);
      exp_q.delete();
      @(negedge clk);
      reset = 1'b0;
      run(12'h010, 12'hFFF, 64'h0, 8, 0, 0, -1);
      for (int r = 0; r < 25; r++) begin
         b  = int'($urandom_range(40, 1));
         e  = b + int'($urandom_range(5, 0)) - 1;
         nb = int'($urandom_range(40, 0));
         run(b, e, {$urandom, $urandom}, nb, 2, 1'($urandom), ($urandom_range(3, 0) == 0) ? int'($urandom_range(10, 0)) : -1);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/jtag_tdo_capture.md
# jtag_tdo_capture

Captures the TDO bit stream returned by the target during JTAG vector playback and packs it into D_WIDTH-bit words written to the second vector RAM port (vector_2). It is the read-back counterpart of the vector player: the player drives TCK/TMS/TDI from vector_1, and this block records the target's responses into vector_2 for the CPU to read through main_ram. It runs in the `clk` domain alongside the vector player.

## Interface

Parameters:
- `D_WIDTH`, 8: vector RAM word width; bits packed per write.
- `A_WIDTH`, 12: vector RAM address width.

Ports:
- `clk`  in  1  system clock; same clock as `vector_ram_clk`.
- `reset`  in  1  asynchronous, active-high reset.
- `capture_start`  in  1  one-cycle pulse that begins a capture run.
- `capture_stop`  in  1  one-cycle pulse that ends the run and flushes any partial word.
- `tdo`  in  1  TDO sample, already in the `clk` domain.
- `tdo_valid`  in  1  one-cycle strobe per TCK period; `tdo` is valid in the same cycle.
- `base_addr`  in  A_WIDTH  first RAM word address; sampled on `capture_start`.
- `end_addr`  in  A_WIDTH  last writable RAM word address, inclusive; sampled on `capture_start`.
- `vector_2_addr`  out  A_WIDTH  RAM write address.
- `vector_2_we`  out  1  RAM write enable, one-cycle pulse.
- `vector_2_wr_data`  out  D_WIDTH  packed TDO word.
- `busy`  out  1  high in CAPTURE and FLUSH.
- `done`  out  1  sticky; set when a run completes, cleared by the next accepted `capture_start`.
- `overflow`  out  1  sticky; set when a bit arrives with no address left, cleared by the next accepted `capture_start`.
- `bit_count`  out  32  number of bits accepted in the current or last run.

## Operation

- States:
  - IDLE: after reset.
  - CAPTURE: accepting bits.
  - FLUSH: one cycle, writes any partial word.
  - DONE: run complete; outputs hold.
- `capture_start` is accepted only in IDLE or DONE. On acceptance:
  - Load the write pointer from `base_addr` and latch `end_addr`.
  - Clear the shift register, the bit index, `bit_count`, `done` and `overflow`.
  - Go to CAPTURE.
- `capture_start` in CAPTURE or FLUSH is ignored.
- In CAPTURE, a `tdo_valid` bit is handled as follows:
  - If the pointer is greater than the latched end address, drop the bit and set `overflow`. `bit_count` is not incremented.
  - Otherwise, store `tdo` LSB-first: the first bit goes to bit 0. Increment the bit index and `bit_count`.
  - When the bit index reaches D_WIDTH, write the word at the pointer, increment the pointer, and clear the bit index and shift register.
- The pointer is A_WIDTH+1 bits internally, so the increment past all-ones registers as overflow rather than wrapping to 0.
- A `capture_stop` in CAPTURE moves the block to FLUSH.
  - If a `tdo_valid` arrives in the same cycle, that bit is accepted first.
- In FLUSH:
  - If the bit index is nonzero and the pointer is not greater than the end address, write the partial word with the unused upper bits set to 0.
  - Then go to DONE and set `done`.
- `tdo_valid` and `capture_stop` are ignored in IDLE, FLUSH and DONE.
- If `base_addr` is greater than `end_addr`, the first bit sets `overflow` and nothing is written.

## Timing

- Reset values:
  - State IDLE.
  - `vector_2_addr`=0, `vector_2_we`=0, `vector_2_wr_data`=0.
  - `busy`=0, `done`=0, `overflow`=0, `bit_count`=0.
  - Internal pointer, shift register and bit index all 0.
- Asserting `reset` mid-run aborts immediately. Any pending write is lost.
- All outputs are registered.
- Start latency: `capture_start` in cycle n gives `busy`=1 from cycle n+1. A bit is accepted if its `tdo_valid` is in cycle n+1 or later.
- Write latency: the `tdo_valid` that completes a word in cycle n gives `vector_2_we`=1 for exactly cycle n+1. `vector_2_addr` and `vector_2_wr_data` are valid in that same cycle.
- Back-to-back `tdo_valid` (every cycle) must be sustained without loss. Consecutive words may produce writes every D_WIDTH cycles.
- Stop latency: `capture_stop` in cycle n gives FLUSH in cycle n+1.
  - The partial write, if any, appears with `vector_2_we` in cycle n+2.
  - `busy` falls and `done` rises in cycle n+2.
- A full word completed by a `tdo_valid` in the same cycle as `capture_stop` is written in cycle n+1. FLUSH then finds the bit index at 0 and does not write.
- `bit_count` updates in the cycle after each accepted bit.

## Test plan

- **Basic packing.** Use base=0x010, end=0xFFF. Start, then send bits 1,0,1,1,0,0,0,0 followed by eight 1s, then stop. Required: writes of 0x0D at 0x010 and 0xFF at 0x011, `bit_count`=16, `done`=1, no third write.
- **Partial flush.** With the same setup, send 11 bits where bits 8..10 are 1,1,0, then stop. Required: the second write is 0x03 at 0x011, occurring two cycles after stop.
- **Overflow.** Use base=end=0x020 and send 20 bits of 1, then stop. Required: exactly one write (0xFF at 0x020), `overflow`=1 from the 9th bit, `bit_count`=8, no flush write.
- **Simultaneous stop and bit.** Send 7 bits, then assert the 8th `tdo_valid` together with `capture_stop`. Required: one full-word write in the next cycle, no flush write, `bit_count`=8.
- **Reset mid-run.** Send 5 bits, assert `reset`, then start a new run and send 8 bits of 0. Required: all outputs 0 immediately on reset, and the new run writes 0x00 at base with no residue of the earlier bits.
- **Start ignored while busy.** Pulse `capture_start` with base=0x100 after 3 bits of a run with base=0x010. Required: the run continues at 0x010 and `bit_count` keeps counting.
